xc_aessub_iter: RTL

- Iterative AES SubBytes functional unit in the execute stage.
- Implements xc.aessub.{enc,encrot,dec,decrot} using one shared S-box, processing one byte per cycle.
- Its ready/result pair feeds writeback.
- Its inputs and outputs are the same operation the formal checker xc_aessub_checker models combinationally, so the checker can be bound directly against it.

---
 rtl/xc_aessub_iter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/xc_aessub_iter.sv
// xc_aessub_iter: iterative AES SubBytes unit for xc.aessub.{enc,encrot,dec,decrot}.
// Default build: one shared S-box, one byte per cycle, ready five cycles after acceptance.
// Define XC_AESSUB_ITER_PARALLEL_EN for four S-boxes and ready two cycles after acceptance.
module xc_aessub_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        rot,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_cnt;
  logic [3:0][7:0] r_t;
  logic [3:0][7:0] r_s;
  logic            r_enc;
  logic            r_rot;
  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic            w_ready;
  logic            w_abort;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(x, x);
    acc = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  // Forward and inverse S-box share one inverter; only the affine steps differ
  function automatic logic [7:0] sbox(input logic [7:0] x, input logic fwd);
    logic [7:0] pre;
    logic [7:0] inv;
    pre = fwd ? x : ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    inv = ginv(pre);
    return fwd ? (inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63)
               : inv;
  endfunction

  assign w_abort = flush || !valid;

`ifdef XC_AESSUB_ITER_PARALLEL_EN
  logic [3:0][7:0] w_sub;
  assign w_last = 1'b1;
  // All four bytes substituted in the single BUSY cycle
  always_comb begin
    w_sub = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_sub[i] = sbox(r_t[i], r_enc);
    end
  end
`else
  logic [7:0] w_sub;
  assign w_last = (r_cnt == 2'd3);
  // Shared S-box walks the latched bytes LSB first
  always_comb begin
    w_sub = sbox(r_t[r_cnt], r_enc);
  end
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, acceptance/step strobes and ready gating
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid && !flush) begin
          w_state_nxt = BUSY;
          w_accept    = 1'b1;
        end
      end
      BUSY: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
          if (w_last) w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_ready     = !w_abort;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, byte results and byte counter (cnt is 0 whenever not stepping)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_t   <= '0;
      r_s   <= '0;
      r_enc <= 1'b0;
      r_rot <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_t   <= {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};
      r_enc <= enc;
      r_rot <= rot;
      r_cnt <= '0;
    end else if (w_step) begin
`ifdef XC_AESSUB_ITER_PARALLEL_EN
      r_s   <= w_sub;
      r_cnt <= '0;
`else
      r_s[r_cnt] <= w_sub;
      r_cnt      <= r_cnt + 2'd1;
`endif
    end else begin
      r_cnt <= '0;
    end
  end

  assign busy   = (r_state != IDLE);
  assign ready  = w_ready;
  assign result = !w_ready ? '0
                : r_rot  ? {r_s[2], r_s[1], r_s[0], r_s[3]}
                :          r_s;

endmodule
